pixie_framebuffer: RTL and testbench

Sits downstream of the CDP1861 video timing block. It captures the DMA byte stream that the 1861 pulls from the 1802 (8 bytes/line, up to 128 lines) into a 1024x8 frame RAM. It re-scans that RAM with its own stable, parameterised timing for the MiSTer video pipeline. This decouples host video timing from the CPU-paced 1861 raster, and blanks cleanly when the display is off.

---
 rtl/pixie_pkg.sv | 19 +
 rtl/pixie_fb_ram.sv | 20 ++
 rtl/pixie_framebuffer.sv | 146 ++++++++++++++
 tb/tb_pixie_framebuffer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pixie_pkg.sv
// Shared constants and types for the Pixie (CDP1861) frame buffer.
// The frame RAM holds 128 source lines of 8 bytes, one bit per source pixel.
package pixie_pkg;
  localparam int SRC_W          = 64;
  localparam int SRC_H          = 128;
  localparam int BYTES_PER_LINE = 8;
  localparam int FB_DEPTH       = 1024;
  localparam int FB_AW          = 10;
  localparam logic [1:0] SC_DMA = 2'b10;

  typedef struct packed {
    logic video;
    logic de;
    logic hsync;
    logic vsync;
    logic hblank;
    logic vblank;
  } pix_out_t;
endpackage

// File: rtl/pixie_fb_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port.
// Contents are never reset, so the array maps onto block RAM.
module pixie_fb_ram
  import pixie_pkg::*;
(
  input  logic             clock,
  input  logic             i_we,
  input  logic [FB_AW-1:0] i_waddr,
  input  logic [7:0]       i_wdata,
  input  logic             i_re,
  input  logic [FB_AW-1:0] i_raddr,
  output logic [7:0]       o_rdata
);
  logic [7:0] r_mem [FB_DEPTH];

  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/pixie_framebuffer.sv
// Captures the 1861 DMA byte stream into frame RAM and re-scans it with
// stable host video timing (4x horizontal, 2x vertical pixel replication).
module pixie_framebuffer
  import pixie_pkg::*;
#(
  parameter int H_ACTIVE     = 256,
  parameter int H_TOTAL      = 342,
  parameter int H_SYNC_START = 280,
  parameter int H_SYNC_END   = 304,
  parameter int V_ACTIVE     = 256,
  parameter int V_TOTAL      = 312,
  parameter int V_SYNC_START = 270,
  parameter int V_SYNC_END   = 273
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] i_sc,
  input  logic       i_tpb,
  input  logic [7:0] i_data_in,
  input  logic       i_int_n,
  input  logic       i_ce_pix,
  output logic       o_video,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_hblank,
  output logic       o_vblank,
  output logic       o_de,
  output logic       o_frame_valid,
  output logic       o_wr_overflow
);
  localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);

  logic             r_tpb_q, r_int_n_q;
  logic [FB_AW-1:0] r_wr_addr;
  logic             r_wr_full, r_frame_valid, r_wr_overflow;
  logic             w_dma_wr, w_int_fall, w_we;
  logic [FB_AW-1:0] w_waddr;

  assign w_dma_wr   = (i_sc == SC_DMA) & i_tpb & ~r_tpb_q;
  assign w_int_fall = r_int_n_q & ~i_int_n;
  // A restart rewinds the write pointer even if the previous frame filled the RAM.
  assign w_we       = w_dma_wr & (w_int_fall | ~r_wr_full);
  assign w_waddr    = w_int_fall ? '0 : r_wr_addr;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_tpb_q       <= 1'b0;
      r_int_n_q     <= 1'b1;
      r_wr_addr     <= '0;
      r_wr_full     <= 1'b0;
      r_frame_valid <= 1'b0;
      r_wr_overflow <= 1'b0;
    end else begin
      r_tpb_q   <= i_tpb;
      r_int_n_q <= i_int_n;
      if (w_int_fall) begin
        r_frame_valid <= (r_wr_addr != '0) | r_wr_full;
        r_wr_addr     <= w_dma_wr ? FB_AW'(1) : '0;
        r_wr_full     <= 1'b0;
        r_wr_overflow <= 1'b0;
      end else if (w_dma_wr) begin
        if (!r_wr_full) begin
          r_wr_addr <= r_wr_addr + 1'b1;
          if (r_wr_addr == FB_AW'(FB_DEPTH - 1)) r_wr_full <= 1'b1;
        end else begin
          r_wr_overflow <= 1'b1;
        end
      end
    end
  end

  logic [8:0] r_hcnt, r_vcnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (i_ce_pix) begin
      if (r_hcnt == H_LAST) begin
        r_hcnt <= '0;
        r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + 1'b1;
      end else begin
        r_hcnt <= r_hcnt + 1'b1;
      end
    end
  end

  // Stage 0 is combinational off the counters; the RAM read register is stage 1.
  logic [FB_AW-1:0] w_rd_addr;
  logic [7:0]       w_rdata;
  logic             w_h_act, w_v_act, w_hs, w_vs;

  assign w_rd_addr = {r_vcnt[7:1], r_hcnt[7:5]};
  assign w_h_act   = r_hcnt < 9'(H_ACTIVE);
  assign w_v_act   = r_vcnt < 9'(V_ACTIVE);
  assign w_hs      = (r_hcnt >= 9'(H_SYNC_START)) & (r_hcnt < 9'(H_SYNC_END));
  assign w_vs      = (r_vcnt >= 9'(V_SYNC_START)) & (r_vcnt < 9'(V_SYNC_END));

  pixie_fb_ram u_ram (
    .clock   (clock),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (i_data_in),
    .i_re    (i_ce_pix),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rdata)
  );

  logic [2:0] r_bitsel;
  logic       r_hact, r_vact, r_hs, r_vs;
  pix_out_t   r_out;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_bitsel <= '0;
      r_hact   <= 1'b0;
      r_vact   <= 1'b0;
      r_hs     <= 1'b0;
      r_vs     <= 1'b0;
      r_out    <= '{video: 1'b0, de: 1'b0, hsync: 1'b0, vsync: 1'b0,
                    hblank: 1'b1, vblank: 1'b1};
    end else if (i_ce_pix) begin
      r_bitsel     <= r_hcnt[4:2];
      r_hact       <= w_h_act;
      r_vact       <= w_v_act;
      r_hs         <= w_hs;
      r_vs         <= w_vs;
      r_out.video  <= r_hact & r_vact & r_frame_valid & w_rdata[3'd7 - r_bitsel];
      r_out.de     <= r_hact & r_vact;
      r_out.hsync  <= r_hs;
      r_out.vsync  <= r_vs;
      r_out.hblank <= ~r_hact;
      r_out.vblank <= ~r_vact;
    end
  end

  assign o_video       = r_out.video;
  assign o_de          = r_out.de;
  assign o_hsync       = r_out.hsync;
  assign o_vsync       = r_out.vsync;
  assign o_hblank      = r_out.hblank;
  assign o_vblank      = r_out.vblank;
  assign o_frame_valid = r_frame_valid;
  assign o_wr_overflow = r_wr_overflow;
endmodule

// File: tb/tb_pixie_framebuffer.sv
// Directed bench for pixie_framebuffer: DMA capture model plus an output
// scoreboard fed from a bench-side raster model (short vertical frame).
module tb_pixie_framebuffer;
  localparam int HT  = 342;
  localparam int VA  = 4;
  localparam int VT  = 8;
  localparam int VSS = 5;
  localparam int VSE = 6;
  localparam logic [5:0] RST_OUT = 6'b000011;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [1:0] i_sc = 2'b00;
  logic i_tpb = 1'b0;
  logic [7:0] i_data_in = 8'h00;
  logic i_int_n = 1'b1;
  logic i_ce_pix = 1'b0;
  logic o_video, o_hsync, o_vsync, o_hblank, o_vblank, o_de, o_frame_valid, o_wr_overflow;

  always #5 clock = ~clock;

  pixie_framebuffer #(
    .V_ACTIVE(VA), .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_END(VSE)
  ) dut (
    .clock(clock), .reset(reset), .i_sc(i_sc), .i_tpb(i_tpb), .i_data_in(i_data_in),
    .i_int_n(i_int_n), .i_ce_pix(i_ce_pix), .o_video(o_video), .o_hsync(o_hsync),
    .o_vsync(o_vsync), .o_hblank(o_hblank), .o_vblank(o_vblank), .o_de(o_de),
    .o_frame_valid(o_frame_valid), .o_wr_overflow(o_wr_overflow)
  );

  wire [5:0] w_obs = {o_video, o_de, o_hsync, o_vsync, o_hblank, o_vblank};

  int nerr = 0;
  int nchk = 0;
  logic [7:0] mem_m [1024];
  int addr_m;
  bit ovf_m, fv_m;
  int hm, vm;
  logic [5:0] sbq [$];
  logic [5:0] last_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] exp_out(input int h, input int v);
    bit ha = h < 256;
    bit va = v < VA;
    int x = (h / 4) % 64;
    int addr = ((v / 2) % 128) * 8 + x / 8;
    logic [7:0] b = mem_m[addr];
    bit vid = ha && va && fv_m && (b[7 - (x % 8)] == 1'b1);
    return {vid, ha && va, (h >= 280) && (h < 304), (v >= VSS) && (v < VSE), !ha, !va};
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // One clock with the output scoreboard active.
  task automatic tick(input string tag);
    logic ce;
    ce = i_ce_pix;
    cyc();
    if (ce) begin
      sbq.push_back(exp_out(hm, vm));
      hm++;
      if (hm == HT) begin
        hm = 0;
        vm = (vm == VT - 1) ? 0 : vm + 1;
      end
      last_out = sbq.pop_front();
    end
    check(tag, 32'(w_obs), 32'(last_out));
  endtask

  task automatic scan(input int n, input string tag);
    i_ce_pix = 1'b1;
    for (int i = 0; i < n; i++) tick(tag);
    i_ce_pix = 1'b0;
  endtask

  task automatic do_reset();
    i_ce_pix = 1'b0;
    reset = 1'b0;
    cyc();
    check("reset_out", 32'(w_obs), 32'(RST_OUT));
    check("reset_fv", 32'(o_frame_valid), 32'd0);
    check("reset_ovf", 32'(o_wr_overflow), 32'd0);
    cyc();
    cyc();
    reset = 1'b1;
    hm = 0; vm = 0; addr_m = 0; ovf_m = 0; fv_m = 0;
    sbq.delete();
    sbq.push_back(RST_OUT);
    last_out = RST_OUT;
  endtask

  task automatic dma(input logic [7:0] d);
    i_sc = 2'b10; i_data_in = d; i_tpb = 1'b1;
    cyc(); cyc();
    i_tpb = 1'b0;
    cyc();
    i_sc = 2'b00;
    if (addr_m < 1024) begin
      mem_m[addr_m] = d;
      addr_m++;
    end else begin
      ovf_m = 1'b1;
    end
  endtask

  task automatic int_fall(input string tag);
    i_int_n = 1'b0;
    cyc();
    i_int_n = 1'b1;
    cyc();
    fv_m = addr_m != 0;
    addr_m = 0;
    ovf_m = 1'b0;
    check({tag, "_fv"}, 32'(o_frame_valid), 32'(fv_m));
    check({tag, "_ovf"}, 32'(o_wr_overflow), 32'(ovf_m));
  endtask

  initial begin
    int hs_cnt;
    for (int i = 0; i < 1024; i++) mem_m[i] = 8'h00;

    do_reset();
    scan(2 * HT, "scan_fv0");

    int_fall("if_empty");
    for (int i = 0; i < 1024; i++) dma(8'(i));
    check("full_flag", 32'(dut.r_wr_full), 32'd1);
    check("full_addr", 32'(dut.r_wr_addr), 32'd0);
    check("full_ovf", 32'(o_wr_overflow), 32'd0);
    check("ram5", 32'(dut.u_ram.r_mem[5]), 32'h05);
    check("ram1023", 32'(dut.u_ram.r_mem[1023]), 32'hFF);
    int_fall("if_1024");

    for (int i = 0; i < 1025; i++) dma(i < 8 ? 8'h80 : (i == 1024 ? 8'h5A : 8'h00));
    check("ovf_set", 32'(o_wr_overflow), 32'(ovf_m));
    check("ram0_kept", 32'(dut.u_ram.r_mem[0]), 32'h80);
    int_fall("if_1025");

    scan(VT * HT, "scan_frame");

    int_fall("if_nodma");
    scan(HT, "scan_nodma");

    i_int_n = 1'b0; i_sc = 2'b10; i_tpb = 1'b1; i_data_in = 8'hAA;
    cyc();
    i_int_n = 1'b1;
    cyc();
    i_tpb = 1'b0;
    cyc();
    i_sc = 2'b00;
    fv_m = addr_m != 0; addr_m = 1; mem_m[0] = 8'hAA; ovf_m = 1'b0;
    check("coin_ram0", 32'(dut.u_ram.r_mem[0]), 32'hAA);
    check("coin_addr", 32'(dut.r_wr_addr), 32'd1);
    check("coin_fv", 32'(o_frame_valid), 32'(fv_m));

    hs_cnt = 0;
    for (int i = 0; i < 2 * HT; i++) begin
      i_ce_pix = (i % 2) == 0;
      tick("scan_half");
      if ((i % 2) == 0 && o_hsync) hs_cnt++;
    end
    i_ce_pix = 1'b0;
    check("hsync_width", 32'(hs_cnt), 32'd24);

    scan(37, "scan_pre_rst");
    do_reset();
    scan(300, "scan_post_rst");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
